// File: rtl/c4_pkg.sv
// Shared constants and types for the Connect Four move sequencer.
// Board geometry, the sequencer FSM state encoding and the thermometer helper
// used both by the height encoder and the write-data generator.
// DROP_ANIM_EN adds the drop-animation state to the FSM encoding.
package c4_pkg;

  localparam int NUM_COLS   = 7;
  localparam int NUM_ROWS   = 6;
  localparam int DROP_TICKS = 4;

  localparam int CW        = $clog2(NUM_COLS);
  localparam int HW        = $clog2(NUM_ROWS + 1);
  localparam int MC_W      = 6;
  localparam int MAX_MOVES = NUM_COLS * NUM_ROWS;

  typedef logic                player_t;
  typedef logic [HW-1:0]       height_t;
  typedef logic [CW-1:0]       col_t;
  typedef logic [NUM_ROWS-1:0] occ_t;
  typedef logic [MC_W-1:0]     count_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_CHECK,
`ifdef DROP_ANIM_EN
    ST_DROP,
`endif
    ST_WRITE,
    ST_REJECT,
    ST_FULL
  } state_t;

  // Thermometer word with the lowest n bits set (n pieces stacked from the bottom).
  function automatic occ_t therm(input int n);
    occ_t w;
    w = '0;
    for (int i = 0; i < NUM_ROWS; i++) begin
      w[i] = (i < n);
    end
    return w;
  endfunction

endpackage

// File: rtl/move_sequencer_col_height_enc.sv
// Column height encoder: converts a thermometer occupancy word (bit0 = bottom)
// into the number of stacked pieces. Any word that is not a clean thermometer
// code is flagged invalid so the sequencer can refuse to stack on a corrupt column.
module col_height_enc
  import c4_pkg::*;
(
  input  occ_t    occ,
  output height_t height,
  output logic    valid
);

  // Match the word against every legal fill level; at most one can hit.
  always_comb begin
    // NOTE: every output gets a default before the search so no path leaves it unassigned (no latch).
    height = '0;
    valid  = 1'b0;
    for (int h = 0; h <= NUM_ROWS; h++) begin
      if (occ == therm(h)) begin
        height = height_t'(h);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/move_sequencer.sv
// Connect Four turn controller. Serves the column-drop request of the player
// whose turn it is, reads the column occupancy word, then either commits the
// piece (occupancy + colour write, ack) or rejects it (nack). Tracks turn,
// committed move count, board-full and a sticky corrupt-word error.
// Optional feature macro: DROP_ANIM_EN (adds a timed drop animation before the write).
module move_sequencer
  import c4_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                game_clr,
  input  logic                p0_req,
  input  logic [CW-1:0]       p0_col,
  input  logic                p1_req,
  input  logic [CW-1:0]       p1_col,
  output logic                p0_ack,
  output logic                p0_nack,
  output logic                p1_ack,
  output logic                p1_nack,
  output logic                occ_rd_en,
  output logic [CW-1:0]       occ_addr,
  input  logic [NUM_ROWS-1:0] occ_rdata,
  output logic                occ_we,
  output logic [NUM_ROWS-1:0] occ_wdata,
  output logic                clr_we,
  output logic [HW-1:0]       clr_row,
  output logic                clr_player,
  output logic                turn,
  output logic [MC_W-1:0]     move_count,
  output logic                board_full,
  output logic                err_corrupt,
  output logic                anim_valid,
  output logic [HW-1:0]       anim_row
);

  state_t  state_q, state_d;
  col_t    col_q, col_d;
  player_t turn_q, turn_d;
  count_t  count_q, count_d;
  logic    full_q, full_d;
  logic    err_q, err_d;
  logic    rd_en_q, rd_en_d;
  logic    we_q, we_d;
  occ_t    wdata_q, wdata_d;
  height_t clr_row_q, clr_row_d;
  player_t clr_player_q, clr_player_d;
  logic    p0_ack_q, p0_ack_d, p1_ack_q, p1_ack_d;
  logic    p0_nack_q, p0_nack_d, p1_nack_q, p1_nack_d;
  logic    anim_valid_q, anim_valid_d;
  height_t anim_row_q, anim_row_d;

`ifdef DROP_ANIM_EN
  localparam int TW = (DROP_TICKS > 1) ? $clog2(DROP_TICKS) : 1;
  height_t       height_q, height_d;
  logic [TW-1:0] tick_q, tick_d;
`endif

  height_t enc_height;
  logic    enc_valid;
  logic    req_turn;
  col_t    col_turn;
  logic    enter_write, enter_reject;
  height_t write_height;

  col_height_enc u_enc (
    .occ    (occ_rdata),
    .height (enc_height),
    .valid  (enc_valid)
  );

  // Only the player whose turn it is can be served; the other request waits.
  assign req_turn = turn_q ? p1_req : p0_req;
  assign col_turn = turn_q ? p1_col : p0_col;

  // Next-state and next-output logic; every output is registered with the state.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    turn_d       = turn_q;
    count_d      = count_q;
    err_d        = err_q;
    rd_en_d      = 1'b0;
    we_d         = 1'b0;
    wdata_d      = wdata_q;
    clr_row_d    = clr_row_q;
    clr_player_d = clr_player_q;
    anim_valid_d = 1'b0;
    anim_row_d   = '0;
    enter_write  = 1'b0;
    enter_reject = 1'b0;
    write_height = '0;
`ifdef DROP_ANIM_EN
    height_d     = height_q;
    tick_d       = tick_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (full_q) begin
          state_d = ST_FULL;
        end else if (req_turn) begin
          col_d = col_turn;
          if (int'(col_turn) >= NUM_COLS) begin
            state_d      = ST_REJECT;
            enter_reject = 1'b1;
          end else begin
            state_d = ST_READ;
            rd_en_d = 1'b1;
          end
        end
      end
      ST_READ: begin
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (!enc_valid) begin
          err_d        = 1'b1;
          state_d      = ST_REJECT;
          enter_reject = 1'b1;
        end else if (enc_height == height_t'(NUM_ROWS)) begin
          state_d      = ST_REJECT;
          enter_reject = 1'b1;
        end else begin
`ifdef DROP_ANIM_EN
          state_d      = ST_DROP;
          height_d     = enc_height;
          tick_d       = '0;
          anim_valid_d = 1'b1;
          anim_row_d   = height_t'(NUM_ROWS - 1);
`else
          state_d      = ST_WRITE;
          enter_write  = 1'b1;
          write_height = enc_height;
`endif
        end
      end
`ifdef DROP_ANIM_EN
      ST_DROP: begin
        if (anim_row_q == height_q) begin
          state_d      = ST_WRITE;
          enter_write  = 1'b1;
          write_height = height_q;
        end else begin
          anim_valid_d = 1'b1;
          if (tick_q == TW'(DROP_TICKS - 1)) begin
            tick_d     = '0;
            anim_row_d = anim_row_q - 1'b1;
          end else begin
            tick_d     = tick_q + 1'b1;
            anim_row_d = anim_row_q;
          end
        end
      end
`endif
      ST_WRITE: begin
        turn_d  = ~turn_q;
        count_d = count_q + 1'b1;
        state_d = ST_IDLE;
      end
      ST_REJECT: begin
        state_d = ST_IDLE;
      end
      ST_FULL: begin
        // One nack per request: a request still high during its own nack is not re-served.
        if (req_turn && !(p0_nack_q || p1_nack_q)) begin
          enter_reject = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Commit strobes: new top word is one more piece than the decoded height.
    if (enter_write) begin
      we_d         = 1'b1;
      wdata_d      = therm(int'(write_height) + 1);
      clr_row_d    = write_height;
      clr_player_d = turn_q;
    end

    p0_ack_d  = enter_write  & ~turn_q;
    p1_ack_d  = enter_write  &  turn_q;
    p0_nack_d = enter_reject & ~turn_q;
    p1_nack_d = enter_reject &  turn_q;
    full_d    = (int'(count_d) == MAX_MOVES);
  end

  // State and output registers; reset and new-game clear override any operation in flight.
  always_ff @(posedge clk) begin
    if (reset || game_clr) begin
      state_q      <= ST_IDLE;
      col_q        <= '0;
      turn_q       <= 1'b0;
      count_q      <= '0;
      full_q       <= 1'b0;
      err_q        <= 1'b0;
      rd_en_q      <= 1'b0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      clr_row_q    <= '0;
      clr_player_q <= 1'b0;
      p0_ack_q     <= 1'b0;
      p1_ack_q     <= 1'b0;
      p0_nack_q    <= 1'b0;
      p1_nack_q    <= 1'b0;
      anim_valid_q <= 1'b0;
      anim_row_q   <= '0;
`ifdef DROP_ANIM_EN
      height_q     <= '0;
      tick_q       <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values of its peers.
      state_q      <= state_d;
      col_q        <= col_d;
      turn_q       <= turn_d;
      count_q      <= count_d;
      full_q       <= full_d;
      err_q        <= err_d;
      rd_en_q      <= rd_en_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      clr_row_q    <= clr_row_d;
      clr_player_q <= clr_player_d;
      p0_ack_q     <= p0_ack_d;
      p1_ack_q     <= p1_ack_d;
      p0_nack_q    <= p0_nack_d;
      p1_nack_q    <= p1_nack_d;
      anim_valid_q <= anim_valid_d;
      anim_row_q   <= anim_row_d;
`ifdef DROP_ANIM_EN
      height_q     <= height_d;
      tick_q       <= tick_d;
`endif
    end
  end

  assign p0_ack      = p0_ack_q;
  assign p1_ack      = p1_ack_q;
  assign p0_nack     = p0_nack_q;
  assign p1_nack     = p1_nack_q;
  assign occ_rd_en   = rd_en_q;
  assign occ_addr    = col_q;
  assign occ_we      = we_q;
  assign occ_wdata   = wdata_q;
  assign clr_we      = we_q;
  assign clr_row     = clr_row_q;
  assign clr_player  = clr_player_q;
  assign turn        = turn_q;
  assign move_count  = count_q;
  assign board_full  = full_q;
  assign err_corrupt = err_q;
  assign anim_valid  = anim_valid_q;
  assign anim_row    = anim_row_q;

endmodule
